// File: rtl/bitcnt_sched.sv
// Shared CLZ/CTZ unit: round-robin arbitration of NUM_REQ requesters onto one
// 32-bit leading-zero counter, sequencing one or two passes for 64-bit ops.
module bitcnt_sched #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TAG_W   = 7,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [64*NUM_REQ-1:0]    req_data,
    input  logic [TAG_W*NUM_REQ-1:0] req_tag,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [6:0]               res_count,
    output logic [ID_W-1:0]          res_id,
    output logic [TAG_W-1:0]         res_tag
);

    typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [1:0]         op_q, op_d;
    logic [63:0]        data_q, data_d;
    logic               res_valid_q, res_valid_d;
    logic [6:0]         res_count_q, res_count_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic               accept;
    logic [1:0]         sel_op;
    logic [63:0]        sel_data;
    logic [TAG_W-1:0]   sel_tag;
    logic [31:0]        lzc_in;
    logic [5:0]         lzc_cnt;

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Round-robin pick: first valid requester after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Grant only while idle, not flushing and out of reset.
    always_comb begin
        accept    = (state_q == StIdle) && !flush && grant_found && rst_n;
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (grant_idx == ID_W'(i));
        end
    end

    // Select the granted requester's operation fields.
    always_comb begin
        sel_op   = '0;
        sel_data = '0;
        sel_tag  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_op   = req_op[2*i +: 2];
                sel_data = req_data[64*i +: 64];
                sel_tag  = req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    // Counter operand: CTZ counts leading zeros of the bit-reversed word, so the
    // low word goes first for CTZ64 and the high word first for CLZ64.
    always_comb begin
        lzc_in = data_q[31:0];
        if (state_q == StPass2) begin
            lzc_in = op_q[0] ? rev32(data_q[63:32]) : data_q[31:0];
        end else begin
            unique case (op_q)
                2'b00:        lzc_in = data_q[31:0];
                2'b10:        lzc_in = data_q[63:32];
                2'b01, 2'b11: lzc_in = rev32(data_q[31:0]);
                default:      lzc_in = data_q[31:0];
            endcase
        end
    end

    // The single shared 32-bit leading-zero counter (0..32).
    always_comb begin
        lzc_cnt = 6'd32;
        for (int unsigned i = 0; i < 32; i++) begin
            if (lzc_in[i]) begin
                lzc_cnt = 6'(31 - i);
            end
        end
    end

    // FSM next-state and registered-output update; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        data_d      = data_q;
        res_valid_d = res_valid_q;
        res_count_d = res_count_q;
        res_id_d    = res_id_q;
        res_tag_d   = res_tag_q;
        if (flush) begin
            state_d     = StIdle;
            res_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d   = StPass1;
                        op_d      = sel_op;
                        data_d    = sel_data;
                        res_id_d  = grant_idx;
                        res_tag_d = sel_tag;
                        rr_ptr_d  = grant_idx;
                    end
                end
                StPass1: begin
                    if (op_q[1] && (lzc_cnt == 6'd32)) begin
                        state_d = StPass2;
                    end else begin
                        res_count_d = {1'b0, lzc_cnt};
                        res_valid_d = 1'b1;
                        state_d     = StDone;
                    end
                end
                StPass2: begin
                    res_count_d = 7'd32 + {1'b0, lzc_cnt};
                    res_valid_d = 1'b1;
                    state_d     = StDone;
                end
                StDone: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers; reset aborts any operation and clears all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            op_q        <= '0;
            data_q      <= '0;
            res_valid_q <= 1'b0;
            res_count_q <= '0;
            res_id_q    <= '0;
            res_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            data_q      <= data_d;
            res_valid_q <= res_valid_d;
            res_count_q <= res_count_d;
            res_id_q    <= res_id_d;
            res_tag_q   <= res_tag_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_count = res_count_q;
    assign res_id    = res_id_q;
    assign res_tag   = res_tag_q;

endmodule

// File: tb/tb_bitcnt_sched.sv
// Bench for bitcnt_sched: directed cases plus randomized traffic, checked by a
// scoreboard fed at request accept and drained by a result monitor.
module tb_bitcnt_sched;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned TAG_W   = 7;
    localparam int unsigned ID_W    = 1;

    logic                     clk;
    logic                     rst_n;
    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [64*NUM_REQ-1:0]    req_data;
    logic [TAG_W*NUM_REQ-1:0] req_tag;
    logic                     res_valid;
    logic                     res_ready;
    logic [6:0]               res_count;
    logic [ID_W-1:0]          res_id;
    logic [TAG_W-1:0]         res_tag;

    bitcnt_sched #(
        .NUM_REQ(NUM_REQ),
        .TAG_W  (TAG_W),
        .ID_W   (ID_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_data (req_data),
        .req_tag  (req_tag),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_count(res_count),
        .res_id   (res_id),
        .res_tag  (res_tag)
    );

    typedef struct {
        int cnt;
        int id;
        int tag;
        int lat;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: count zeros directly from the operand bits.
    function automatic int lz(input logic [63:0] v, input int w);
        int n = 0;
        for (int b = w - 1; b >= 0; b--) begin
            if (v[b]) return n;
            n++;
        end
        return n;
    endfunction

    function automatic int tz(input logic [63:0] v, input int w);
        int n = 0;
        for (int b = 0; b < w; b++) begin
            if (v[b]) return n;
            n++;
        end
        return n;
    endfunction

    function automatic int model_count(input logic [1:0] op, input logic [63:0] v);
        case (op)
            2'b00:   return lz(v, 32);
            2'b01:   return tz(v, 32);
            2'b10:   return lz(v, 64);
            default: return tz(v, 64);
        endcase
    endfunction

    // Two passes only when the first-examined 32-bit word of a 64-bit op is zero.
    function automatic int model_lat(input logic [1:0] op, input logic [63:0] v);
        if (!op[1]) return 2;
        if (!op[0]) return (v[63:32] == 32'd0) ? 3 : 2;
        return (v[31:0] == 32'd0) ? 3 : 2;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: pushes expectations on accept, pops and compares on result handshake,
    // and checks latency, output hold under backpressure and grant exclusivity.
    initial begin
        logic       prev_v, prev_r, prev_f;
        logic [6:0] p_cnt;
        logic       p_id;
        logic [6:0] p_tag;
        exp_t       e;
        prev_v = 0; prev_r = 0; prev_f = 0; p_cnt = 0; p_id = 0; p_tag = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0;
            end else begin
                if (res_valid && !prev_v) begin
                    if (sb.size() == 0) begin
                        chk("result_expected", 0, 1);
                    end else begin
                        chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
                    end
                end
                if (res_valid) chk("ready_low_in_done", req_ready, 0);
                chk("ready_onehot", ($countones(req_ready) <= 1) ? 1 : 0, 1);
                if (prev_v && !prev_r && !prev_f) begin
                    chk("hold_valid", res_valid, 1);
                    chk("hold_count", res_count, p_cnt);
                    chk("hold_id", res_id, p_id);
                    chk("hold_tag", res_tag, p_tag);
                end
                if (res_valid && res_ready && !flush) begin
                    if (sb.size() == 0) begin
                        chk("sb_nonempty", 0, 1);
                    end else begin
                        e = sb.pop_front();
                        chk("res_count", res_count, e.cnt);
                        chk("res_id", res_id, e.id);
                        chk("res_tag", res_tag, e.tag);
                    end
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        e.cnt     = model_count(req_op[2*i +: 2], req_data[64*i +: 64]);
                        e.lat     = model_lat(req_op[2*i +: 2], req_data[64*i +: 64]);
                        e.id      = i;
                        e.tag     = int'(req_tag[TAG_W*i +: TAG_W]);
                        e.acc_cyc = cyc;
                        sb.push_back(e);
                    end
                end
                prev_v = res_valid;
                prev_r = res_ready;
                prev_f = flush;
                p_cnt  = res_count;
                p_id   = res_id;
                p_tag  = res_tag;
            end
        end
    end

    task automatic set_req(input int r, input logic [1:0] op, input logic [63:0] d,
                           input logic [TAG_W-1:0] t);
        req_op[2*r +: 2]         = op;
        req_data[64*r +: 64]     = d;
        req_tag[TAG_W*r +: TAG_W] = t;
    endtask

    // Waits at negedges until requester r is granted; the handshake edge follows.
    task automatic wait_accept(input int r);
        int n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (req_ready[r]) break;
            n++;
        end
        if (n >= 20) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (sb.size() == 0 && !res_valid) break;
            n++;
        end
        if (n >= 40) chk("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_op(input int r, input logic [1:0] op, input logic [63:0] d,
                         input logic [TAG_W-1:0] t, input int exp_cnt);
        int n = 0;
        set_req(r, op, d, t);
        req_valid[r] = 1'b1;
        wait_accept(r);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        while (n < 10) begin
            @(negedge clk);
            if (res_valid) break;
            n++;
        end
        if (n >= 10) chk("result_timeout", 0, 1);
        chk("dir_count", res_count, exp_cnt);
        chk("dir_id", res_id, r);
        chk("dir_tag", res_tag, t);
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] gen_data();
        logic [63:0] v;
        v = {32'($urandom), 32'($urandom)};
        case ($urandom % 6)
            0:       return v;
            1:       return {32'd0, v[31:0]};
            2:       return {v[63:32], 32'd0};
            3:       return 64'd0;
            4:       return 64'd1 << ($urandom % 64);
            default: return v >> ($urandom % 64);
        endcase
    endfunction

    initial begin
        logic [NUM_REQ-1:0] acc;
        int                 g;
        int                 n;
        clk = 0; rst_n = 0; flush = 0; req_valid = '0; res_ready = 1'b1;
        req_op = '0; req_data = '0; req_tag = '0;

        // Reset values, with both requesters asking.
        #3 req_valid = 2'b11;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_count", res_count, 0);
        req_valid = '0;
        #19 rst_n = 1;
        @(posedge clk); #1;

        // Two continuously valid requesters alternate starting with 0.
        set_req(0, 2'b00, 64'h0000_0000_0001_0000, 7'h11);
        set_req(1, 2'b00, 64'h0000_0000_0000_00f0, 7'h22);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = -1;
            n = 0;
            while (n < 20 && g < 0) begin
                @(negedge clk);
                if (req_ready == 2'b01) g = 0;
                else if (req_ready == 2'b10) g = 1;
                n++;
            end
            chk("alt_grant", g, k % 2);
            @(posedge clk); #1;
        end
        req_valid = '0;
        wait_idle();

        // Directed counts, including two-pass and boundary values.
        do_op(0, 2'b00, 64'h0000_0000_0001_0000, 7'h05, 15);
        do_op(0, 2'b00, 64'h0,                   7'h06, 32);
        do_op(1, 2'b10, 64'h0000_0000_0000_0001, 7'h07, 63);
        do_op(1, 2'b10, 64'h0,                   7'h08, 64);
        do_op(1, 2'b10, 64'h8000_0000_0000_0000, 7'h09, 0);
        do_op(0, 2'b11, 64'h8000_0000_0000_0000, 7'h0a, 63);
        do_op(0, 2'b11, 64'h0000_0000_0000_0100, 7'h0b, 8);
        do_op(1, 2'b01, 64'hffff_ffff_0000_0000, 7'h0c, 32);

        // Backpressure: result held, no grants while it waits.
        res_ready = 1'b0;
        set_req(0, 2'b00, 64'h0000_0000_0001_0000, 7'h15);
        req_valid[0] = 1'b1;
        wait_accept(0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(1, 2'b00, 64'h0000_0000_0000_00ff, 7'h16);
        req_valid[1] = 1'b1;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (res_valid) break;
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_valid", res_valid, 1);
            chk("stall_ready", req_ready, 0);
            chk("stall_count", res_count, 15);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_accept(1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_idle();

        // Flush during the second pass.
        set_req(1, 2'b10, 64'h1, 7'h31);
        req_valid[1] = 1'b1;
        wait_accept(1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        set_req(0, 2'b00, 64'h1, 7'h32);
        set_req(1, 2'b00, 64'h3, 7'h33);
        req_valid = 2'b11;
        @(negedge clk);
        chk("flush_ready", req_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_no_result", res_valid, 0);
        chk("flush_rr_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Reset in the middle of the first pass.
        set_req(1, 2'b10, 64'h1, 7'h41);
        req_valid[1] = 1'b1;
        wait_accept(1);
        @(posedge clk); #1;
        set_req(0, 2'b00, 64'h8000_0000, 7'h42);
        req_valid = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", res_valid, 0);
        chk("arst_count", res_count, 0);
        chk("arst_id", res_id, 0);
        chk("arst_tag", res_tag, 0);
        chk("arst_ready", req_ready, 0);
        sb.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_first_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = (($urandom % 3) != 0);
                    set_req(i, 2'($urandom), gen_data(), 7'($urandom));
                end
            end
            res_ready = (($urandom % 4) != 0);
        end
        req_valid = '0;
        res_ready = 1'b1;
        wait_idle();
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bitcnt_sched.md
# bitcnt_sched

Shared leading/trailing-zero count unit for the integer execute stage. Arbitrates up to NUM_REQ requesters round-robin onto a single internal 32-bit leading-zero counter. Computes 32- and 64-bit CLZ/CTZ by sequencing one or two passes through that counter. Returns each result with the requester's id and tag over a valid/ready handshake, and supports a synchronous pipeline flush.

## Interface
- NUM_REQ, 2, number of requesters (≥2)
- TAG_W, 7, width of the opaque per-request tag
- ID_W, $clog2(NUM_REQ), requester index width (derived)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of the in-flight operation
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero)
- req_op  in  2*NUM_REQ  per requester: 00 CLZ32, 01 CTZ32, 10 CLZ64, 11 CTZ64
- req_data  in  64*NUM_REQ  per-requester operand; 32-bit ops use [31:0]
- req_tag  in  TAG_W*NUM_REQ  per-requester tag, returned unchanged
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_count  out  7  zero count, range 0..64
- res_id  out  ID_W  index of the requester that issued the result
- res_tag  out  TAG_W  tag of that request

## Operation
- Internal counter: one 32-bit combinational leading-zero counter, output 0..32, fed from a 32-bit operand mux. CTZ is formed by bit-reversing the selected word. No second counter instance.
- FSM states: IDLE, PASS1, PASS2, DONE.
- IDLE: the arbiter selects the first valid requester starting at rr_ptr+1 (mod NUM_REQ). req_ready is high for that requester only, and only when flush=0. On req_valid&req_ready: latch op, data, tag and id; set rr_ptr to the granted index; go to PASS1.
- PASS1 operand: CLZ32 data[31:0]; CTZ32 rev(data[31:0]); CLZ64 data[63:32]; CTZ64 rev(data[31:0]).
  - For 32-bit ops, or when count<32: res_count=count, go to DONE.
  - For a 64-bit op with count==32: go to PASS2.
- PASS2 operand: CLZ64 data[31:0]; CTZ64 rev(data[63:32]). res_count=32+count (7-bit, max 64); go to DONE.
- DONE: res_valid=1. res_count, res_id and res_tag are held stable until res_ready. On handshake, go to IDLE.
- req_ready is 0 in PASS1, PASS2 and DONE. The unit holds one operation at a time.
- flush=1 in any state:
  - next state is IDLE, res_valid deasserts on the next edge, and the in-flight result is discarded;
  - req_ready is 0 during the flush cycle;
  - rr_ptr is unchanged.
- Requesters must hold op/data/tag stable while valid&&!ready. The block does not check this.
- Reset (async assert):
  - state IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first);
  - res_valid=0, res_count=0, res_id=0, res_tag=0;
  - req_ready=0 while rst_n=0.
- Reset mid-operation aborts immediately. No result is produced for the aborted op.

## Timing
- Accept handshake in cycle 0 → PASS1 in cycle 1 → res_valid=1 in cycle 2 (single pass).
- Two-pass 64-bit ops (upper/first word all zero): res_valid=1 in cycle 3.
- Result handshake in cycle n → IDLE in n+1. The earliest next accept is cycle n+1, so peak throughput is 1 op per 3 cycles single-pass and 1 per 4 cycles two-pass.
- req_ready is combinational from req_valid, rr_ptr, state and flush. No combinational path exists from res_ready to req_ready.
- All result outputs are registered.

## Test plan
- Req0 CLZ32 data=0x0000_0000_0001_0000, res_ready=1 → res_valid in cycle 2 after accept, res_count=15, res_id=0, tag echoed; CLZ32 data=0 → 32.
- Req1 CLZ64 data=0x0000_0000_0000_0001 → res_count=63 in cycle 3; data=0 → 64; data=0x8000_0000_0000_0000 → 0 in cycle 2.
- CTZ64 data=0x8000_0000_0000_0000 → 63 (two-pass); CTZ64 data=0x0000_0000_0000_0100 → 8 (single pass); CTZ32 data=0xFFFF_FFFF_0000_0000 → 32.
- Both requesters valid continuously with distinct tags → grants alternate 0,1,0,1 starting with 0; res_id and res_tag match each grant.
- res_ready low for 5 cycles in DONE → res_count/res_id/res_tag stable and req_ready=0 throughout; result drains when res_ready rises.
- Flush asserted in PASS2 → no res_valid for that op, state IDLE next cycle, next request accepted with rr order preserved. rst_n pulsed low mid-PASS1 → all outputs 0 asynchronously, and req0 wins first after release.
